// File: rtl/i2s_audio_tx_pkg.sv
// Shared constants, slot type and the per-slot data-bit rule for the I2S serializer.
package i2s_pkg;

    localparam int unsigned SLOTS_PER_FRAME = 64;
    localparam int unsigned SLOT_BITS       = 32;

    typedef logic [5:0] slot_t;

    // Channel bit 0 is the Philips one-BCK delay; bits 1..width carry the sample MSB-first.
    function automatic logic slot_bit(slot_t s, logic [30:0] sample, int unsigned width);
        logic [4:0] ch;
        logic [4:0] idx;
        ch  = s[4:0];
        idx = '0;
        if (ch != 5'd0 && 32'(ch) <= width) begin
            idx = 5'(width - 32'(ch));
            return sample[idx];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/i2s_audio_tx_if.sv
// Sample-source handshake: the source presents left/right words, the serializer strobes on capture.
interface i2s_audio_tx_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] left_in;
    logic [WIDTH-1:0] right_in;
    logic             sample_strobe;

    modport master (output left_in, output right_in, input  sample_strobe);
    modport slave  (input  left_in, input  right_in, output sample_strobe);
endinterface

// File: rtl/i2s_audio_tx_bck_gen.sv
// Integer divider producing the I2S bit clock plus single-cycle rise/fall event strobes.
module i2s_bck_gen #(
    parameter int unsigned BCK_HALF_DIV = 8
) (
    input  logic clk_i,
    input  logic clr_i,
    output logic bck_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);
    localparam int unsigned CW = $clog2(BCK_HALF_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bck_q, bck_d;
    logic          tick;

    always_comb begin
        tick  = (cnt_q == CW'(BCK_HALF_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        bck_d = bck_q ^ tick;
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
            bck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bck_q <= bck_d;
        end
    end

    // Events are qualified by the pre-toggle level so they coincide with the bck edge itself.
    assign rise_tick_o = tick & ~bck_q;
    assign fall_tick_o = tick &  bck_q;
    assign bck_o       = bck_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips-format I2S transmitter: 64 BCK per frame, samples latched once per frame at slot 0.
module i2s_audio_tx
    import i2s_pkg::*;
#(
    parameter int unsigned BCK_HALF_DIV = 8,
    parameter int unsigned WIDTH        = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ena,
    i2s_audio_tx_if.slave  src,
    output logic           i2s_bck,
    output logic           i2s_lrck,
    output logic           i2s_data
);
    logic clr;
    logic rise_tick, fall_tick;

    slot_t            slot_q, slot_d, slot_nxt;
    logic             lrck_q, lrck_d;
    logic             data_q, data_d;
    logic             strobe_q, strobe_d;
    logic [WIDTH-1:0] hold_l_q, hold_l_d;
    logic [WIDTH-1:0] hold_r_q, hold_r_d;

    assign clr = reset | ~ena;

    i2s_bck_gen #(
        .BCK_HALF_DIV (BCK_HALF_DIV)
    ) u_bck_gen (
        .clk_i       (clk),
        .clr_i       (clr),
        .bck_o       (i2s_bck),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    always_comb begin
        slot_nxt = slot_q + 6'd1;
        slot_d   = slot_q;
        lrck_d   = lrck_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        if (fall_tick) begin
            slot_d = slot_nxt;
            lrck_d = slot_nxt[5];
            if (slot_nxt == 6'd0) begin
                hold_l_d = src.left_in;
                hold_r_d = src.right_in;
                strobe_d = 1'b1;
            end
            // Slot 0 must already see the freshly captured word, hence the _d selection.
            data_d = slot_bit(slot_nxt,
                              slot_nxt[5] ? 31'(hold_r_d) : 31'(hold_l_d),
                              WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            slot_q   <= '1;
            lrck_q   <= 1'b0;
            data_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            lrck_q   <= lrck_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    // Hold registers deliberately survive reset/disable.
    always_ff @(posedge clk) begin
        hold_l_q <= hold_l_d;
        hold_r_q <= hold_r_d;
    end

    assign i2s_lrck          = lrck_q;
    assign i2s_data          = data_q;
    assign src.sample_strobe = strobe_q;

    logic unused_rise;
    assign unused_rise = rise_tick;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: cycle-accurate scoreboard plus frame-level scenario checks.
module tb_i2s_audio_tx;
    localparam int unsigned D  = 8;
    localparam int unsigned DB = 2;
    localparam int unsigned WB = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, ena;
    logic bck_a, lrck_a, data_a;
    logic bck_b, lrck_b, data_b;

    i2s_audio_tx_if #(.WIDTH(16)) ifa ();
    i2s_audio_tx_if #(.WIDTH(WB)) ifb ();

    i2s_audio_tx #(.BCK_HALF_DIV(D), .WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .ena(ena), .src(ifa),
        .i2s_bck(bck_a), .i2s_lrck(lrck_a), .i2s_data(data_a)
    );

    i2s_audio_tx #(.BCK_HALF_DIV(DB), .WIDTH(WB)) dut_b (
        .clk(clk), .reset(reset), .ena(ena), .src(ifb),
        .i2s_bck(bck_b), .i2s_lrck(lrck_b), .i2s_data(data_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model for dut_a, derived from absolute cycle count since release.
    typedef struct packed {
        logic bck;
        logic lrck;
        logic data;
        logic strobe;
    } out_t;

    out_t        sbq[$];
    int unsigned mcyc;
    int unsigned ms, mch;
    logic [15:0] ml, mr;
    logic        mlrck, mdata;
    out_t        me, ce;

    always @(posedge clk) begin
        if (reset || !ena) begin
            mcyc  = 0;
            mlrck = 1'b0;
            mdata = 1'b0;
            me    = '0;
        end else begin
            mcyc++;
            me.strobe = 1'b0;
            if (mcyc % (2 * D) == 0) begin
                ms  = ((mcyc / (2 * D)) - 1) % 64;
                mch = ms % 32;
                if (ms == 0) begin
                    ml        = ifa.left_in;
                    mr        = ifa.right_in;
                    me.strobe = 1'b1;
                end
                mlrck = (ms >= 32);
                if (mch >= 1 && mch <= 16)
                    mdata = (ms >= 32) ? mr[16 - mch] : ml[16 - mch];
                else
                    mdata = 1'b0;
            end
            me.bck  = ((mcyc / D) % 2) == 1;
            me.lrck = mlrck;
            me.data = mdata;
        end
        sbq.push_back(me);
    end

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            ce = sbq.pop_front();
            check("out", 64'({bck_a, lrck_a, data_a, ifa.sample_strobe}), 64'(ce));
        end
    end

    task automatic wait_strobe(input bit sel, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if ((sel ? ifb.sample_strobe : ifa.sample_strobe) === 1'b1) return;
            if (n > 3000) begin
                check("strobe_timeout", 64'(0), 64'(1));
                n = -1;
                return;
            end
        end
    endtask

    task automatic collect(input bit sel, input int chg_at, input logic [15:0] chg_val,
                           output logic [63:0] d, output logic [63:0] l);
        int   n, t;
        logic pb, b;
        d = '0;
        l = '0;
        wait_strobe(sel, n);
        if (n < 0) return;
        pb = 1'b0;
        for (int i = 0; i < 64; i++) begin
            t = 0;
            forever begin
                @(negedge clk);
                t++;
                b = sel ? bck_b : bck_a;
                if (b && !pb) break;
                pb = b;
                if (t > 100) break;
            end
            if (t > 100) begin
                check("rise_timeout", 64'(0), 64'(1));
                return;
            end
            pb = b;
            d  = {d[62:0], sel ? data_b : data_a};
            l  = {l[62:0], sel ? lrck_b : lrck_a};
            if (i == chg_at) ifa.left_in = chg_val;
        end
    endtask

    initial begin
        logic [63:0] d, l;
        int          n, first_hi, first_lo, nstb, stb0, stb1;

        reset = 1'b1;
        ena   = 1'b1;
        ifa.left_in  = 16'h8001;
        ifa.right_in = 16'h7FFE;
        ifb.left_in  = 24'hA5A5A5;
        ifb.right_in = '0;

        repeat (3) begin
            @(negedge clk);
            check("rst_outs", 64'({bck_a, lrck_a, data_a, ifa.sample_strobe}), 64'(0));
        end
        reset = 1'b0;

        // Release timing
        first_hi = -1; first_lo = -1; nstb = 0; stb0 = -1; stb1 = -1;
        for (int c = 1; c <= 1041; c++) begin
            @(negedge clk);
            if (bck_a && first_hi < 0) first_hi = c;
            if (!bck_a && first_hi >= 0 && first_lo < 0) first_lo = c;
            if (ifa.sample_strobe) begin
                nstb++;
                if (stb0 < 0) stb0 = c; else if (stb1 < 0) stb1 = c;
            end
        end
        check("bck_first_hi", 64'(first_hi), 64'(D));
        check("bck_first_lo", 64'(first_lo), 64'(2 * D));
        check("strobe_count", 64'(nstb), 64'(2));
        check("strobe_first", 64'(stb0), 64'(2 * D));
        check("strobe_second", 64'(stb1), 64'(130 * D));

        // Bit pattern of a full frame
        collect(1'b0, -1, 16'h0, d, l);
        check("frame_data", d, {1'b0, 16'h8001, 15'h0, 1'b0, 16'h7FFE, 15'h0});
        check("frame_lrck", l, {32'h0, 32'hFFFF_FFFF});

        // Mid-frame input change is deferred to the next frame
        ifa.left_in = 16'h1234;
        collect(1'b0, 10, 16'hFFFF, d, l);
        check("hold_cur", d[63:32], 64'({1'b0, 16'h1234, 15'h0}));
        collect(1'b0, -1, 16'h0, d, l);
        check("hold_next", d[63:32], 64'({1'b0, 16'hFFFF, 15'h0}));

        // One-clock reset at slot 40
        collect(1'b0, -1, 16'h0, d, l);
        wait_strobe(1'b0, n);
        repeat (40 * 2 * D + D) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_outs", 64'({bck_a, lrck_a, data_a}), 64'(0));
        reset = 1'b0;
        wait_strobe(1'b0, n);
        check("midrst_strobe", 64'(n), 64'(2 * D));

        // Enable low for 100 clk mid-frame
        repeat (20 * 2 * D) @(negedge clk);
        ena = 1'b0;
        repeat (100) begin
            @(negedge clk);
            check("ena_low_outs", 64'({bck_a, lrck_a, data_a, ifa.sample_strobe}), 64'(0));
        end
        ena = 1'b1;
        wait_strobe(1'b0, n);
        check("ena_strobe_first", 64'(n), 64'(2 * D));
        wait_strobe(1'b0, n);
        check("ena_strobe_period", 64'(n), 64'(128 * D));

        // D=2, WIDTH=24 instance
        collect(1'b1, -1, 16'h0, d, l);
        check("w24_left", d[63:32], 64'({1'b0, 24'hA5A5A5, 7'h0}));
        check("w24_right", d[31:0], 64'(0));
        check("w24_lrck", l, {32'h0, 32'hFFFF_FFFF});
        wait_strobe(1'b1, n);
        wait_strobe(1'b1, n);
        check("w24_frame", 64'(n), 64'(256));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
